// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

  localparam int SKID_DEPTH = 3;

  // Wide enough for a count of 0..3 and for pointers 0..2.
  typedef logic [1:0] skid_cnt_t;

  // Advance a circular pointer, wrapping 2 -> 0.
  function automatic skid_cnt_t ptr_inc(input skid_cnt_t p);
    return (p == skid_cnt_t'(SKID_DEPTH - 1)) ? skid_cnt_t'(0) : skid_cnt_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry circular register buffer that absorbs the FIFO read latency.
// Entries are cleared on reset so the head word reads as zero while empty.
module stream_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output skid_cnt_t        count
);

  logic [SKID_DEPTH-1:0][WIDTH-1:0] mem;
  skid_cnt_t                        head;
  skid_cnt_t                        tail;

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the single-clock DPRAM FIFO onto a valid/ready stream.
// Reads are issued only from registered state and i_Empty, so there is
// no combinational path from i_Ready to o_Rd_En. The skid buffer holds
// enough room for every read that might still be in flight.
// Optional feature macro: FIFO_RD_STREAM_LAST_EN (adds o_Last and a beat counter).
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  output logic             o_Rd_En,
  input  logic             i_Rd_DV,
  input  logic [WIDTH-1:0] i_Rd_Data,
  input  logic             i_Empty,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  input  logic             i_Ready
`ifdef FIFO_RD_STREAM_LAST_EN
  ,
  output logic             o_Last
`endif
);

  logic      r_Run;
  logic      inflight;
  logic      pop;
  skid_cnt_t buf_count;
  logic [2:0] occupancy;

  // Start reading one clock after reset release; track the word the FIFO owes us.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Run    <= 1'b0;
      inflight <= 1'b0;
    end else begin
      r_Run    <= 1'b1;
      inflight <= o_Rd_En;
    end
  end

  // Count the in-flight word as already occupying a slot.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight};
  assign o_Rd_En   = r_Run & ~i_Empty & (occupancy < 3'(SKID_DEPTH));
  assign o_Valid   = (buf_count != '0);
  assign pop       = o_Valid & i_Ready;

  stream_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .push      (i_Rd_DV),
    .push_data (i_Rd_Data),
    .pop       (pop),
    .head_data (o_Data),
    .count     (buf_count)
  );

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [15:0] beat;

  // Beat position within the packet, advanced on each accepted word.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)  beat <= '0;
    else if (pop)  beat <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
  end

  assign o_Last = o_Valid & (beat == LAST_BEAT);
`endif

  // Packet length must fit the 16-bit beat counter.
  a_pkt_len: assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
    (PKT_LEN >= 1) && (PKT_LEN <= 65535));

  // Read issue never lets a capture land on a full buffer.
  a_no_overflow: assert property (@(posedge i_Clk) disable iff (!i_Rst_L)
    !(i_Rd_DV && (buf_count == skid_cnt_t'(SKID_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;

  logic             i_Clk = 1'b0;
  logic             i_Rst_L;
  logic             o_Rd_En;
  logic             i_Rd_DV;
  logic [WIDTH-1:0] i_Rd_Data;
  logic             i_Empty;
  logic             o_Valid;
  logic [WIDTH-1:0] o_Data;
  logic             i_Ready;
`ifdef FIFO_RD_STREAM_LAST_EN
  logic             o_Last;
  logic             last_last;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  logic             last_rd, last_vld, last_acc;
  logic [WIDTH-1:0] last_data;
  int               beats;

  always #5 i_Clk = ~i_Clk;

  fifo_rd_stream #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
    .i_Clk     (i_Clk),
    .i_Rst_L   (i_Rst_L),
    .o_Rd_En   (o_Rd_En),
    .i_Rd_DV   (i_Rd_DV),
    .i_Rd_Data (i_Rd_Data),
    .i_Empty   (i_Empty),
    .o_Valid   (o_Valid),
    .o_Data    (o_Data),
    .i_Ready   (i_Ready)
`ifdef FIFO_RD_STREAM_LAST_EN
    ,
    .o_Last    (o_Last)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push n words into the FIFO model and the scoreboard.
  task automatic load(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + WIDTH'(i));
      exp_q.push_back(base + WIDTH'(i));
    end
    i_Empty = (fifo_q.size() == 0);
  endtask

  // One clock: sample at negedge, score accepted words, then model the FIFO after the edge.
  task automatic tick();
    logic [WIDTH-1:0] want;
    @(negedge i_Clk);
    last_rd   = o_Rd_En;
    last_vld  = o_Valid;
    last_data = o_Data;
    last_acc  = o_Valid && i_Ready;
`ifdef FIFO_RD_STREAM_LAST_EN
    last_last = o_Last;
`endif
    if (last_acc) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("data_order", 32'(o_Data), 32'(want));
      end
      beats++;
    end
    @(posedge i_Clk);
    #1;
    if (i_Rst_L) begin
      i_Rd_DV = last_rd;
      if (last_rd && fifo_q.size() != 0) i_Rd_Data = fifo_q.pop_front();
    end else begin
      i_Rd_DV = 1'b0;
    end
    i_Empty = (fifo_q.size() == 0);
  endtask

  initial begin
    int first_rd, first_vld, rdc, run, run_max, bub, unstable, n;
    logic started;
    logic [WIDTH-1:0] d0;

    // ---- 1: reset, preload 4 words ----
    i_Rst_L = 1'b0; i_Ready = 1'b1; i_Empty = 1'b1; i_Rd_DV = 1'b0; i_Rd_Data = '0;
    beats = 0;
    #3;
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_data", 32'(o_Data), 32'd0);
    load(4, 8'h01);
    tick();
    check("rd_en_in_reset", 32'(last_rd), 32'd0);
    i_Rst_L = 1'b1;
    tick();
    check("rd_en_after_release", 32'(last_rd), 32'd0);
    first_rd = -1; first_vld = -1;
    for (int k = 0; k < 20 && beats < 4; k++) begin
      tick();
      if (last_rd && first_rd < 0)   first_rd = k;
      if (last_vld && first_vld < 0) first_vld = k;
    end
    check("t1_first_rd", 32'(first_rd), 32'd0);
    check("t1_latency", 32'(first_vld - first_rd), 32'd2);
    check("t1_beats", 32'(beats), 32'd4);
    repeat (3) tick();

    // ---- 2: 64-word burst, full rate ----
    beats = 0; rdc = 0; run = 0; run_max = 0; bub = 0; started = 1'b0;
    load(64, 8'h40);
    for (int k = 0; k < 120 && beats < 64; k++) begin
      tick();
      if (last_rd) begin rdc++; run++; if (run > run_max) run_max = run; end
      else run = 0;
      if (last_acc) started = 1'b1;
      else if (started && beats < 64) bub++;
    end
    check("t2_beats", 32'(beats), 32'd64);
    check("t2_rd_cycles", 32'(rdc), 32'd64);
    check("t2_rd_run", 32'(run_max), 32'd64);
    check("t2_bubbles", 32'(bub), 32'd0);
    repeat (3) tick();

    // ---- 3: backpressure mid-burst ----
    beats = 0; unstable = 0;
    load(20, 8'hA0);
    repeat (5) tick();
    i_Ready = 1'b0;
    tick();
    d0 = last_data;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (last_data !== d0 || !last_vld) unstable++;
    end
    check("t3_stall_stable", 32'(unstable), 32'd0);
    check("t3_stall_rd_en", 32'(last_rd), 32'd0);
    check("t3_buffered", 32'(dut.buf_count), 32'd3);
    i_Ready = 1'b1;
    for (int k = 0; k < 60 && beats < 20; k++) tick();
    check("t3_beats", 32'(beats), 32'd20);
    check("t3_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    // ---- 4: FIFO runs empty, refill 5 clocks later ----
    beats = 0;
    load(6, 8'h80);
    n = 0;
    while (!i_Empty && n < 20) begin tick(); n++; end
    check("t4_went_empty", 32'(i_Empty), 32'd1);
    repeat (5) tick();
    check("t4_valid_dropped", 32'(last_vld), 32'd0);
    check("t4_beats_before", 32'(beats), 32'd6);
    load(4, 8'h90);
    first_vld = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_vld && first_vld < 0) first_vld = k;
    end
    check("t4_resume_latency", 32'(first_vld), 32'd2);
    check("t4_beats_after", 32'(beats), 32'd10);
    repeat (3) tick();

    // ---- 5: reset with count=2, inflight=1 ----
    beats = 0;
    i_Ready = 1'b0;
    load(6, 8'hC0);
    repeat (3) tick();
    check("t5_pre_count", 32'(dut.buf_count), 32'd2);
    check("t5_pre_inflight", 32'(dut.inflight), 32'd1);
    i_Rst_L = 1'b0;
    #1;
    check("t5_async_valid", 32'(o_Valid), 32'd0);
    fifo_q.delete(); exp_q.delete();
    i_Rd_DV = 1'b0; i_Empty = 1'b1;
    repeat (2) tick();
    i_Rst_L = 1'b1;
    i_Ready = 1'b1;
    load(5, 8'hD0);
    for (int k = 0; k < 20 && beats < 5; k++) tick();
    repeat (3) tick();
    check("t5_beats", 32'(beats), 32'd5);
    check("t5_scoreboard_empty", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_STREAM_LAST_EN
    // ---- 6: o_Last framing with random ready ----
    begin
      int idx, lasts;
      i_Rst_L = 1'b0;
      repeat (2) tick();
      i_Rst_L = 1'b1;
      beats = 0; idx = 0; lasts = 0;
      load(12, 8'hE0);
      for (int k = 0; k < 300 && beats < 12; k++) begin
        i_Ready = 1'($urandom_range(0, 1));
        tick();
        if (last_acc) begin
          check("t6_last_beat", 32'(last_last), 32'((idx % PKT_LEN) == PKT_LEN - 1));
          if (last_last) lasts++;
          idx++;
        end else if (!last_vld) begin
          check("t6_last_idle", 32'(last_last), 32'd0);
        end
      end
      check("t6_beats", 32'(beats), 32'd12);
      check("t6_last_count", 32'(lasts), 32'd3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
